// File: rtl/seg7_pattern_monitor.sv
// Watches a 7-segment bus, debounces it, decodes the accepted glyph back to hex
// and measures how many cycles each accepted pattern was held.
module seg7_pattern_monitor #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       segments,
   output logic             frame_strobe,
   output logic [6:0]       pattern,
   output logic [3:0]       digit,
   output logic             digit_valid,
   output logic             is_blank,
   output logic [CNT_W-1:0] hold_cycles,
   output logic [7:0]       change_count
);

   typedef enum logic [1:0] {S_EMPTY, S_STABLE, S_SETTLE} state_t;

   localparam logic [7:0] STAB_MAX  = 8'(STABLE_CYCLES);
   localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);

   state_t           state;
   state_t           state_nxt;
   logic [6:0]       seg_q;
   logic [6:0]       cand;
   logic [7:0]       stab_cnt;
   logic [CNT_W-1:0] run_cnt;
   logic             reach;
   logic             accept;
   logic [4:0]       cand_dec;

   // Returns {valid, digit}; anything outside the 16 hex glyphs decodes to zero.
   function automatic logic [4:0] decode(input logic [6:0] p);
      logic [4:0] r;
      case (p)
         7'h3F:   r = 5'h10;
         7'h06:   r = 5'h11;
         7'h5B:   r = 5'h12;
         7'h4F:   r = 5'h13;
         7'h66:   r = 5'h14;
         7'h6D:   r = 5'h15;
         7'h7D:   r = 5'h16;
         7'h07:   r = 5'h17;
         7'h7F:   r = 5'h18;
         7'h6F:   r = 5'h19;
         7'h77:   r = 5'h1A;
         7'h7C:   r = 5'h1B;
         7'h39:   r = 5'h1C;
         7'h5E:   r = 5'h1D;
         7'h79:   r = 5'h1E;
         7'h71:   r = 5'h1F;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_q    <= '0;
         cand     <= '0;
         stab_cnt <= '0;
      end else begin
         seg_q <= segments;
         if (seg_q != cand) begin
            cand     <= seg_q;
            stab_cnt <= 8'd1;
         end else if (stab_cnt != STAB_MAX) begin
            stab_cnt <= stab_cnt + 8'd1;
         end
      end
   end

   // reach is the single edge on which the candidate's run hits the threshold.
   assign reach    = (seg_q == cand) && (stab_cnt == STAB_LAST);
   assign cand_dec = decode(cand);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_EMPTY:  if (reach) state_nxt = S_STABLE;
         S_STABLE: if (seg_q != pattern) state_nxt = S_SETTLE;
         S_SETTLE: if (reach) state_nxt = S_STABLE;
         default:  state_nxt = S_EMPTY;
      endcase
   end

   always_comb begin
      accept = 1'b0;
      case (state)
         S_EMPTY:  accept = reach;
         S_SETTLE: accept = reach && (cand != pattern);
         default:  accept = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_strobe <= 1'b0;
         pattern      <= '0;
         digit        <= '0;
         digit_valid  <= 1'b0;
         is_blank     <= 1'b0;
         hold_cycles  <= '0;
         change_count <= '0;
         run_cnt      <= '0;
      end else begin
         frame_strobe <= accept;
         if (accept) begin
            pattern      <= cand;
            digit        <= cand_dec[3:0];
            digit_valid  <= cand_dec[4];
            is_blank     <= (cand == 7'h00);
            change_count <= change_count + 8'd1;
            hold_cycles  <= run_cnt;
            run_cnt      <= CNT_W'(1);
         end else if (state != S_EMPTY && run_cnt != '1) begin
            // Saturates so a very long hold still reads as "at least this long".
            run_cnt <= run_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_seg7_pattern_monitor.sv
// Directed plus random stimulus for seg7_pattern_monitor, checked every cycle
// against a run-length model of the sampled segment stream.
module tb_seg7_pattern_monitor;

   localparam int STABLE_CYCLES = 4;
   localparam int CNT_W         = 24;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [6:0]       segments = 7'h00;
   logic             frame_strobe;
   logic [6:0]       pattern;
   logic [3:0]       digit;
   logic             digit_valid;
   logic             is_blank;
   logic [CNT_W-1:0] hold_cycles;
   logic [7:0]       change_count;

   int tests = 0;
   int failed = 0;
   int strobes_seen = 0;

   logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Reference state: run of identical samples, plus the last accepted outputs.
   logic [6:0] m_last = 7'h00;
   int         m_run = 1;
   logic       m_have = 1'b0;
   logic [6:0] m_pat = 7'h00;
   logic [3:0] m_digit = 4'h0;
   logic       m_valid = 1'b0;
   logic       m_blank = 1'b0;
   logic       m_strobe = 1'b0;
   int         m_hold = 0;
   logic [7:0] m_cnt = 8'h00;
   int         edge_n = 0;
   int         last_acc = 0;

   seg7_pattern_monitor #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .segments     (segments),
      .frame_strobe (frame_strobe),
      .pattern      (pattern),
      .digit        (digit),
      .digit_valid  (digit_valid),
      .is_blank     (is_blank),
      .hold_cycles  (hold_cycles),
      .change_count (change_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // A value is accepted on the edge after its run of samples reaches exactly
   // STABLE_CYCLES, provided it differs from what is already shown.
   task automatic model_edge(input logic [6:0] seg, input logic rst);
      if (!rst) begin
         m_last = 7'h00; m_run = 1; m_have = 1'b0; m_pat = 7'h00;
         m_digit = 4'h0; m_valid = 1'b0; m_blank = 1'b0; m_strobe = 1'b0;
         m_hold = 0; m_cnt = 8'h00; edge_n = 0; last_acc = 0;
      end else begin
         edge_n++;
         m_strobe = 1'b0;
         if (m_run == STABLE_CYCLES && (!m_have || m_last != m_pat)) begin
            m_strobe = 1'b1;
            m_hold   = m_have ? edge_n - last_acc : 0;
            last_acc = edge_n;
            m_have   = 1'b1;
            m_pat    = m_last;
            m_cnt    = m_cnt + 8'd1;
            m_digit  = 4'h0;
            m_valid  = 1'b0;
            for (int i = 0; i < 16; i++)
               if (glyph[i] == m_last) begin
                  m_digit = 4'(i);
                  m_valid = 1'b1;
               end
            m_blank = (m_last == 7'h00);
         end
         if (seg == m_last) begin
            if (m_run < 1000) m_run++;
         end else begin
            m_last = seg;
            m_run  = 1;
         end
      end
   endtask

   task automatic step(input logic [6:0] seg, input logic rst);
      @(negedge clk);
      segments = seg;
      rst_n    = rst;
      @(posedge clk);
      model_edge(seg, rst);
      #1;
      if (frame_strobe === 1'b1) strobes_seen++;
      check("strobe", 32'(frame_strobe), 32'(m_strobe));
      check("pattern", 32'(pattern), 32'(m_pat));
      check("digit", 32'(digit), 32'(m_digit));
      check("digit_valid", 32'(digit_valid), 32'(m_valid));
      check("is_blank", 32'(is_blank), 32'(m_blank));
      check("hold_cycles", 32'(hold_cycles), 32'(m_hold));
      check("change_count", 32'(change_count), 32'(m_cnt));
   endtask

   task automatic hold_for(input logic [6:0] seg, input int n);
      for (int i = 0; i < n; i++) step(seg, 1'b1);
   endtask

   initial begin
      logic [6:0] rv;
      int         len;

      step(7'h00, 1'b0);
      step(7'h00, 1'b0);
      check("reset_pattern", 32'(pattern), 32'h0);
      check("reset_count", 32'(change_count), 32'h0);

      // First accept: strobe on the fifth edge after presentation.
      strobes_seen = 0;
      hold_for(7'h06, 4);
      check("lat_no_early", 32'(strobes_seen), 32'd0);
      hold_for(7'h06, 1);
      check("first_strobe", 32'(frame_strobe), 32'd1);
      check("first_digit", 32'(digit), 32'd1);
      check("first_hold", 32'(hold_cycles), 32'd0);
      check("first_count", 32'(change_count), 32'd1);
      hold_for(7'h06, 15);
      hold_for(7'h5B, 5);
      check("second_strobe", 32'(frame_strobe), 32'd1);
      check("second_digit", 32'(digit), 32'd2);
      check("second_hold", 32'(hold_cycles), 32'd20);
      hold_for(7'h5B, 5);

      // Short glitch that returns to the shown value.
      strobes_seen = 0;
      hold_for(7'h4F, 3);
      hold_for(7'h5B, 10);
      check("glitch_no_strobe", 32'(strobes_seen), 32'd0);
      check("glitch_pattern", 32'(pattern), 32'h5B);
      check("glitch_count", 32'(change_count), 32'd2);

      hold_for(7'h49, 6);
      check("unknown_valid", 32'(digit_valid), 32'd0);
      check("unknown_blank", 32'(is_blank), 32'd0);
      hold_for(7'h00, 8);
      check("blank_flag", 32'(is_blank), 32'd1);

      strobes_seen = 0;
      for (int i = 0; i < 50; i++) step(i[0] ? 7'h06 : 7'h3F, 1'b1);
      hold_for(7'h71, 10);
      check("toggle_one_strobe", 32'(strobes_seen), 32'd1);
      check("toggle_digit", 32'(digit), 32'hF);

      // Reset in the middle of settling on a new value.
      hold_for(7'h7F, 2);
      step(7'h7F, 1'b0);
      check("midreset_pattern", 32'(pattern), 32'h0);
      check("midreset_count", 32'(change_count), 32'h0);
      check("midreset_hold", 32'(hold_cycles), 32'h0);
      hold_for(7'h7F, 5);
      check("post_reset_strobe", 32'(frame_strobe), 32'd1);
      check("post_reset_hold", 32'(hold_cycles), 32'd0);
      check("post_reset_count", 32'(change_count), 32'd1);

      for (int i = 0; i < 90; i++) begin
         rv  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : glyph[$urandom_range(0, 15)];
         len = $urandom_range(1, 8);
         hold_for(rv, len);
      end

      step(7'h00, 1'b0);
      for (int i = 0; i < 256; i++) hold_for(i[0] ? 7'h06 : 7'h3F, 5);
      check("count_wrap", 32'(change_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
